// File: rtl/instr_encoder_loader_if.sv
// Field-tuple input handshake and IMEM write bus of the instruction encoder/loader.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  // session control
  logic              start;
  logic              finish;
  // field tuple handshake
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        fmt;
  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shiftam;
  logic [5:0]        funct;
  logic [15:0]       constant;
  // IMEM write port and status
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              full;
  logic              done;
  logic              err;

  // Program source side
  modport master (
    output start, finish, in_valid, fmt, opcode, rs, rt, rd, shiftam, funct, constant,
    input  in_ready, imem_we, imem_addr, imem_wdata, word_count, full, done, err
  );

  // Encoder/loader side
  modport slave (
    input  start, finish, in_valid, fmt, opcode, rs, rt, rd, shiftam, funct, constant,
    output in_ready, imem_we, imem_addr, imem_wdata, word_count, full, done, err
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs MIPS instruction fields into R/I/J words and writes them sequentially into IMEM
// during a start/finish delimited load session.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  instr_encoder_loader_if.slave   bus
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FULL
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_done;
  logic              r_err;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_legal;
  logic [31:0]       w_word;
  logic [ADDR_W:0]   w_count_inc;

  assign w_in_ready  = (r_state == S_LOAD) && (r_count < DEPTH_C);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_legal     = (bus.fmt != 2'd3);
  assign w_count_inc = r_count + (ADDR_W+1)'(1);

  // Field packing; I and J share a layout since the J target is {rs,rt,constant}
  always_comb begin
    w_word = '0;
    case (bus.fmt)
      2'd0:    w_word = {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shiftam, bus.funct};
      2'd1,
      2'd2:    w_word = {bus.opcode, bus.rs, bus.rt, bus.constant};
      default: w_word = '0;
    endcase
  end

  // Session FSM with registered write port; a finish on the same edge as an accept
  // takes priority over the move to FULL so the session still closes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= BASE_C;
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= BASE_C;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_LOAD;
            r_count <= '0;
            r_ptr   <= BASE_C;
            r_err   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (w_legal) begin
              r_we    <= 1'b1;
              r_addr  <= r_ptr;
              r_wdata <= w_word;
              r_ptr   <= r_ptr + ADDR_W'(1);
              r_count <= w_count_inc;
              if (w_count_inc == DEPTH_C) begin
                r_state <= S_FULL;
              end
            end else begin
              r_err <= 1'b1;
            end
          end
          if (bus.finish) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        S_FULL: begin
          if (bus.finish) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.word_count = r_count;
  assign bus.full       = (r_state == S_FULL);
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule
